// File: rtl/mul12_seq_pkg.sv
// Shared constants and types for the 12-bit sequential shift-and-add multiplier.
package mul12_seq_pkg;

  localparam int MUL_WIDTH = 12;
  localparam int CNT_W     = 4;

  // The final iteration is the one where the counter reads WIDTH-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mul12_seq_adder12bits.sv
// Existing 12-bit ripple-carry adder stage that the multiplier iterates around.
module adder12bits (
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  input  logic        i_cin,
  output logic [11:0] o_s,
  output logic        o_cout
);

  logic [12:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 12; i++) begin : g_bit
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[12];

endmodule

// File: rtl/mul12_seq.sv
// Sequential unsigned 12x12 multiplier: one add-and-shift per clock, 12 iterations.
module mul12_seq
  import mul12_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             o_dbg_state
);

  // Handshake: start is accepted only while busy=0 (IDLE); busy stays high for
  // the 12 iterations; done pulses for one cycle when product is updated.
  state_t               r_state;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;

  assign w_addend = r_q[0] ? r_m : '0;

  adder12bits u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Carry-out becomes the accumulator MSB so the shift never loses a bit.
          r_acc  <= {w_cout, w_sum[WIDTH-1:1]};
          r_q    <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          r_done <= 1'b0;
          if (r_cnt == LAST_CNT) begin
            r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul12_seq.sv
// Directed self-checking bench for the sequential 12x12 multiplier.
module tb_mul12_seq;
  import mul12_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] a;
  logic [11:0] b;
  logic        busy;
  logic        done;
  logic [23:0] product;
  state_t      o_dbg_state;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] last_prod;
  int          n;
  int          done_cnt;

  mul12_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic issue(input logic [11:0] ta, input logic [11:0] tb);
    start = 1'b1;
    a     = ta;
    b     = tb;
    step();
    start = 1'b0;
    a     = 12'($urandom_range(0, 4095));
    b     = 12'($urandom_range(0, 4095));
    check("state_run", 24'(o_dbg_state), 24'(ST_RUN));
  endtask

  // Waits for done (bounded); inj>0 pulses a stray start with a=1,b=1 at that cycle.
  task automatic wait_done(input string tag, input int inj, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == inj) begin
        start = 1'b1;
        a     = 12'd1;
        b     = 12'd1;
      end
      step();
      start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
      check({tag, "_busy"}, 24'(busy), 24'd1);
      check({tag, "_hold"}, product, last_prod);
    end
  endtask

  task automatic run_op(input string tag, input logic [11:0] ta, input logic [11:0] tb,
                        input logic [23:0] exp, input int inj);
    int cyc;
    issue(ta, tb);
    wait_done(tag, inj, cyc);
    check({tag, "_latency"}, 24'(cyc), 24'd12);
    check({tag, "_product"}, product, exp);
    check({tag, "_busy_end"}, 24'(busy), 24'd0);
    last_prod = exp;
    step();
    check({tag, "_done_pulse"}, 24'(done), 24'd0);
    check({tag, "_held"}, product, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    last_prod = '0;
    step();
    step();
    check("rst_busy", 24'(busy), 24'd0);
    check("rst_done", 24'(done), 24'd0);
    check("rst_product", product, 24'h000000);
    check("rst_state", 24'(o_dbg_state), 24'(ST_IDLE));
    rst_n = 1'b1;
    step();

    run_op("m3x5", 12'd3, 12'd5, 24'h00000F, 0);
    run_op("mfffxfff", 12'hFFF, 12'hFFF, 24'hFFE001, 0);
    run_op("m0xabc", 12'h000, 12'hABC, 24'h000000, 0);
    run_op("m800x2", 12'h800, 12'h002, 24'h001000, 0);

    // Stray start at cycle 5 while busy must be ignored; count done pulses after.
    run_op("m7x9", 12'd7, 12'd9, 24'h00003F, 5);
    done_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) done_cnt++;
      step();
    end
    check("m7x9_extra_done", 24'(done_cnt), 24'd0);
    check("m7x9_after", product, 24'h00003F);

    // Asynchronous reset in the middle of an operation.
    issue(12'h123, 12'h456);
    for (int k = 0; k < 5; k++) step();
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 24'(busy), 24'd0);
    check("abort_done", 24'(done), 24'd0);
    check("abort_product", product, 24'h000000);
    check("abort_state", 24'(o_dbg_state), 24'(ST_IDLE));
    step();
    step();
    rst_n = 1'b1;
    last_prod = '0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) done_cnt++;
    end
    check("abort_no_done", 24'(done_cnt), 24'd0);
    run_op("m2x3", 12'd2, 12'd3, 24'h000006, 0);

    // Back-to-back: restart in the done cycle.
    issue(12'd5, 12'd6);
    wait_done("b2b_first", 0, n);
    check("b2b_first_latency", 24'(n), 24'd12);
    check("b2b_first_product", product, 24'h00001E);
    last_prod = 24'h00001E;
    run_op("b2b_second", 12'd10, 12'd10, 24'h000064, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
